// File: rtl/boot_loader.sv
// Byte-stream program loader: owns the memory port from reset until an
// image is written, then hands the port to the CPU as a pass-through.
module boot_loader #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              error
);

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DAT_LO,
    DAT_HI,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] count;
  logic [15:0] index;
  logic [15:0] word;
  logic [15:0] n_full;
  logic        accept;
  logic        run_q;

  assign accept = in_valid && in_ready;
  // full word count as seen while count_hi is on the bus
  assign n_full = {in_data, count[7:0]};
  assign cpu_run = run_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CNT_LO;
      count <= '0;
      index <= '0;
      word  <= '0;
      run_q <= 1'b0;
    end else begin
      state <= state_n;
      run_q <= (state_n == DONE);
      if (accept) begin
        unique case (state)
          CNT_LO:  count[7:0]  <= in_data;
          CNT_HI:  count[15:8] <= in_data;
          DAT_LO:  word[7:0]   <= in_data;
          DAT_HI:  word[15:8]  <= in_data;
          default: ;
        endcase
      end
      if (state == WRITE)
        index <= index + 16'd1;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    error     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      CNT_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept)
          state_n = CNT_HI;
      end
      CNT_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (n_full == 16'd0)
            state_n = DONE;
          else if (n_full > 16'(MAX_WORDS))
            state_n = ERR;
          else
            state_n = DAT_LO;
        end
      end
      DAT_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept)
          state_n = DAT_HI;
      end
      DAT_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept)
          state_n = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(index);
        mem_wdata = DATA_W'(word);
        if (index + 16'd1 == count)
          state_n = DONE;
        else
          state_n = DAT_LO;
      end
      DONE: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      ERR: begin
        error = 1'b1;
      end
      default: state_n = CNT_LO;
    endcase
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes are queued by the
// stimulus and popped by a monitor whenever the loader drives a write.
module tb_boot_loader;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_run;
  logic          busy;
  logic          error;

  int total = 0;
  int bad   = 0;
  int acc   = 0;
  int acc0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    last_addr;

  boot_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && in_valid && in_ready)
      acc++;

  // loader writes only: pass-through traffic has cpu_run=1
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (!rst && mem_we && !cpu_run) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%h data=%h want none",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          bad++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   mem_addr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_in_write got=%b want=0", in_ready);
      end
      last_addr = mem_addr;
    end
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout got ready=0 want ready=1 byte=%h", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc0 = acc;
  endtask

  task automatic check_reset_outs(input string nm);
    chk({nm, "_run"}, 32'(cpu_run), 0);
    chk({nm, "_busy"}, 32'(busy), 1);
    chk({nm, "_rdy"}, 32'(in_ready), 1);
    chk({nm, "_err"}, 32'(error), 0);
    chk({nm, "_we"}, 32'(mem_we), 0);
    chk({nm, "_addr"}, 32'(mem_addr), 0);
    chk({nm, "_wdata"}, 32'(mem_wdata), 0);
  endtask

  task automatic basic_image(input bit gap);
    logic [7:0] img [8];
    img = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hff, 8'h81};
    expect_wr(0, 16'h0000);
    expect_wr(1, 16'h0000);
    expect_wr(2, 16'h81ff);
    for (int i = 0; i < 8; i++)
      send(img[i], gap);
    @(negedge clk);
    chk("write3_run", 32'(cpu_run), 0);
    @(negedge clk);
    chk("done_run", 32'(cpu_run), 1);
    chk("done_busy", 32'(busy), 0);
    chk("accepts", 32'(acc - acc0), 8);
    chk("queue_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    cpu_we    = 1'b1;
    cpu_addr  = 15'h0007;
    cpu_wdata = 16'h5555;
    #12;
    check_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;
    acc0 = acc;

    basic_image(1'b0);

    cpu_we    = 1'b1;
    cpu_addr  = 15'h0005;
    cpu_wdata = 16'habcd;
    #1;
    chk("pt_we", 32'(mem_we), 1);
    chk("pt_addr", 32'(mem_addr), 5);
    chk("pt_wdata", 32'(mem_wdata), 32'h abcd);
    cpu_we = 1'b0;
    #1;
    chk("pt_we0", 32'(mem_we), 0);
    cpu_we    = 1'b1;
    cpu_addr  = 15'h0007;
    cpu_wdata = 16'h5555;

    do_reset();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    @(negedge clk);
    chk("empty_run", 32'(cpu_run), 1);
    chk("empty_busy", 32'(busy), 0);
    chk("empty_queue", 32'(exp_q.size()), 0);

    do_reset();
    send(8'h81, 1'b0);
    send(8'h00, 1'b0);
    acc0 = acc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("err_flag", 32'(error), 1);
    chk("err_rdy", 32'(in_ready), 0);
    chk("err_run", 32'(cpu_run), 0);
    chk("err_busy", 32'(busy), 0);
    chk("err_accepts", 32'(acc - acc0), 0);

    do_reset();
    send(8'h80, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 0; i < 128; i++) begin
      logic [7:0] lo;
      logic [7:0] hi;
      lo = 8'(i);
      hi = 8'(i) ^ 8'h5a;
      expect_wr(AW'(i), {hi, lo});
      send(lo, 1'b0);
      send(hi, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    chk("max_run", 32'(cpu_run), 1);
    chk("max_err", 32'(error), 0);
    chk("max_last_addr", 32'(last_addr), 127);
    chk("max_queue", 32'(exp_q.size()), 0);
    chk("max_accepts", 32'(acc - acc0), 258);

    do_reset();
    basic_image(1'b1);

    do_reset();
    expect_wr(0, 16'h2211);
    expect_wr(1, 16'h4433);
    send(8'h03, 1'b0);
    send(8'h00, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outs("midrst");
    @(negedge clk);
    rst = 1'b0;
    acc0 = acc;
    expect_wr(0, 16'h1234);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'h34, 1'b0);
    send(8'h12, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("reload_run", 32'(cpu_run), 1);
    chk("reload_queue", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
